pipe_arbiter: RTL

Round-robin scheduler that time-shares one external bit-serial pipeline_buffer chain (DEPTH stages, 1 bit wide) among NREQ bit-serial requesters. Each grant transfers one fixed-length frame of FRAME bits into the chain. A parallel tag pipeline tracks the source and validity of every bit, so the chain output is returned with its requester ID. The block sits between the branch-metric/serializer producers of the decoder and the shared delay line.

---
 rtl/pipe_arb_pkg.sv | 23 ++
 rtl/pipe_arbiter_if.sv | 45 ++++
 rtl/pipe_arbiter_rr_arbiter.sv | 48 ++++
 rtl/pipe_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_arb_pkg.sv
// ---------------------------------------------------------------------------
// pipe_arb_pkg
//
// Shared definitions for the pipe_arbiter block: the scheduler state encoding
// and the width helper used to size the requester ID and internal counters.
// ---------------------------------------------------------------------------
package pipe_arb_pkg;

    // Scheduler states: waiting for work, streaming a frame into the chain,
    // and waiting for the chain to empty after the last frame.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Bits needed to encode values 0..n-1, never less than one bit so that a
    // degenerate count still produces a legal vector.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : pipe_arb_pkg

// File: rtl/pipe_arbiter_if.sv
// ---------------------------------------------------------------------------
// pipe_arbiter_if
//
// Bundles the requester-side and chain-side signals of pipe_arbiter.
//
//   req       requester -> arbiter   request per requester
//   bit_in    requester -> arbiter   serial data per requester
//   gnt       arbiter -> requester   one-hot grant, held for a whole frame
//   pipe_ip   arbiter -> chain       bit driven into the chain head
//   pipe_op   chain -> arbiter       bit returned from the chain tail
//   bit_out   arbiter -> consumer    pipe_op passed through
//   out_valid arbiter -> consumer    bit_out belongs to a frame
//   out_id    arbiter -> consumer    source requester of bit_out
//   busy      arbiter -> consumer    scheduler not idle
//
// Modports: slave is the arbiter's view, master is the surrounding system's.
// ---------------------------------------------------------------------------
interface pipe_arbiter_if #(
    parameter int NREQ = 4
) ();
    import pipe_arb_pkg::*;

    localparam int IDW = id_width(NREQ);

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] bit_in;
    logic [NREQ-1:0] gnt;
    logic            pipe_ip;
    logic            pipe_op;
    logic            bit_out;
    logic            out_valid;
    logic [IDW-1:0]  out_id;
    logic            busy;

    modport slave (
        input  req, bit_in, pipe_op,
        output gnt, pipe_ip, bit_out, out_valid, out_id, busy
    );

    modport master (
        output req, bit_in, pipe_op,
        input  gnt, pipe_ip, bit_out, out_valid, out_id, busy
    );

endinterface : pipe_arbiter_if

// File: rtl/pipe_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//
// Purely combinational round-robin pick. The search starts one position past
// the previous winner and wraps, so the previous winner is only reselected
// when it is the sole requester.
//
//   req    in   NREQ  request vector
//   last   in   IDW   ID of the previous winner
//   grant  out  NREQ  one-hot winner (zero when no request)
//   id     out  IDW   encoded winner (zero when no request)
//   valid  out  1     at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
    import pipe_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]             req,
    input  logic [id_width(NREQ)-1:0]   last,
    output logic [NREQ-1:0]             grant,
    output logic [id_width(NREQ)-1:0]   id,
    output logic                        valid
);

    localparam int IDW = id_width(NREQ);

    int idx;

    // NOTE: every output gets a default before the search loop; a path that
    // leaves a combinational output unassigned would infer a latch.
    always_comb begin
        grant = '0;
        id    = '0;
        valid = 1'b0;
        idx   = 0;
        // Offsets 1..NREQ visit every requester once, ending on 'last' itself.
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last) + i) % NREQ;
            if (!valid && req[idx]) begin
                valid      = 1'b1;
                grant[idx] = 1'b1;
                id         = IDW'(idx);
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/pipe_arbiter.sv
// ---------------------------------------------------------------------------
// pipe_arbiter
//
// Time-shares one external bit-serial delay chain (DEPTH stages) among NREQ
// bit-serial requesters. Each grant streams a fixed FRAME-bit frame from the
// winner into the chain. A DEPTH-stage tag pipeline runs alongside the chain
// so every bit leaving the chain is labelled with its source and validity.
//
//   clk   in  rising-edge clock
//   rst   in  synchronous active-low reset
//   bus   slave modport of pipe_arbiter_if (req, bit_in, gnt, pipe_ip,
//             pipe_op, bit_out, out_valid, out_id, busy)
//
// The granted requester's ID is held in last_q for the duration of its
// frame, which doubles as the round-robin pointer for the next pick.
// ---------------------------------------------------------------------------
module pipe_arbiter
    import pipe_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DEPTH = 3,
    parameter int FRAME = 8
) (
    input  logic           clk,
    input  logic           rst,
    pipe_arbiter_if.slave  bus
);

    localparam int IDW = id_width(NREQ);
    localparam int BW  = id_width(FRAME);
    localparam int DW  = id_width(DEPTH);

    localparam logic [BW-1:0]  LAST_BEAT  = BW'(FRAME - 1);
    localparam logic [DW-1:0]  LAST_DRAIN = DW'(DEPTH - 1);
    localparam logic [IDW-1:0] RESET_LAST = IDW'(NREQ - 1);

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
    } tag_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e              state_q, state_d;
    logic [NREQ-1:0]     gnt_q,   gnt_d;
    logic [IDW-1:0]      last_q,  last_d;
    logic [BW-1:0]       beat_q,  beat_d;
    logic [DW-1:0]       drain_q, drain_d;
    tag_t [DEPTH-1:0]    tag_q,   tag_d;

    // -----------------------------------------------------------------------
    // Round-robin pick, evaluated every cycle but only acted on at
    // arbitration points (IDLE, DRAIN, last beat of XFER).
    // -----------------------------------------------------------------------
    logic [NREQ-1:0] arb_gnt;
    logic [IDW-1:0]  arb_id;
    logic            arb_valid;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .req   (bus.req),
        .last  (last_q),
        .grant (arb_gnt),
        .id    (arb_id),
        .valid (arb_valid)
    );

    logic in_xfer;
    assign in_xfer = (state_q == XFER);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    logic start;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        beat_d  = beat_q;
        drain_d = drain_q;
        start   = 1'b0;

        unique case (state_q)
            IDLE: begin
                start = arb_valid;
            end

            XFER: begin
                if (beat_q == LAST_BEAT) begin
                    // Re-arbitrate on the last beat so a pending request
                    // follows without a bubble.
                    if (arb_valid) begin
                        start = 1'b1;
                    end else begin
                        state_d = DRAIN;
                        gnt_d   = '0;
                        beat_d  = '0;
                        drain_d = '0;
                    end
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end

            DRAIN: begin
                // A new request abandons the drain count; bits already in the
                // chain keep their tags because the tag pipeline never stalls.
                if (arb_valid) begin
                    start = 1'b1;
                end else if (drain_q == LAST_DRAIN) begin
                    state_d = IDLE;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                beat_d  = '0;
                drain_d = '0;
            end
        endcase

        if (start) begin
            state_d = XFER;
            gnt_d   = arb_gnt;
            last_d  = arb_id;
            beat_d  = '0;
            drain_d = '0;
        end
    end

    // -----------------------------------------------------------------------
    // Tag pipeline: mirrors the external chain one stage per cycle.
    // Idle cycles carry an invalid tag with ID 0.
    // -----------------------------------------------------------------------
    always_comb begin
        tag_d          = tag_q;
        tag_d[0].valid = in_xfer;
        tag_d[0].id    = in_xfer ? last_q : '0;
        for (int i = 1; i < DEPTH; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    // NOTE: the tag pipeline is reset along with the control state; this is
    // what discards in-flight tags so stale chain contents read as invalid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= RESET_LAST;
            beat_q  <= '0;
            drain_q <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            drain_q <= drain_d;
            tag_q   <= tag_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.gnt       = gnt_q;
    assign bus.pipe_ip   = in_xfer ? bus.bit_in[last_q] : 1'b0;
    assign bus.bit_out   = bus.pipe_op;
    assign bus.out_valid = tag_q[DEPTH-1].valid;
    assign bus.out_id    = tag_q[DEPTH-1].id;
    assign bus.busy      = (state_q != IDLE);

endmodule : pipe_arbiter
